// File: rtl/atm_pkg.sv
// Definitions shared by the ATM keypad front end and card_handling.
package atm_pkg;

  localparam int unsigned PIN_DIGITS  = 4;
  localparam int unsigned PIN_DIGIT_W = 4;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_BACK  = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hE;

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} pin_state_e;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/pin_inactivity_timer.sv
// Inactivity counter: flags expiry after IDLE_TIMEOUT running cycles, then restarts.
module pin_inactivity_timer #(
  parameter int unsigned IDLE_TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int unsigned TW = $clog2(IDLE_TIMEOUT);

  logic [TW-1:0] cnt_q;

  // clear beats expiry so a key in the final cycle keeps the entry alive
  assign expire = run && !clear && (cnt_q == TW'(IDLE_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear || expire) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_pin_entry.sv
// Collects keypad digit strobes into a packed BCD PIN and offers it to card_handling
// with a valid/ack handshake; supports backspace, clear, enter and an inactivity wipe.
module keypad_pin_entry #(
  parameter int unsigned DIGITS       = atm_pkg::PIN_DIGITS,
  parameter int unsigned DIGIT_W      = atm_pkg::PIN_DIGIT_W,
  parameter int unsigned PSW_W        = DIGITS * DIGIT_W,
  parameter int unsigned IDLE_TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  input  logic             pin_ack,
  output logic [PSW_W-1:0] password_input,
  output logic             pin_valid,
  output logic [2:0]       digit_count,
  output logic             short_entry,
  output logic             entry_timeout
);

  import atm_pkg::*;

  pin_state_e       state_q;
  logic [PSW_W-1:0] pw_q;
  logic [2:0]       cnt_q;
  logic             valid_q, short_q, timeout_q;

  logic key_digit, key_clear, key_back, key_enter, key_activity;
  logic in_collect, timer_clear, timer_run, timer_expire;

  assign key_digit    = key_valid && is_digit(key_code);
  assign key_clear    = key_valid && (key_code == KEY_CLEAR);
  assign key_back     = key_valid && (key_code == KEY_BACK);
  assign key_enter    = key_valid && (key_code == KEY_ENTER);
  // Any recognised key counts as activity; undefined codes do not keep the entry alive.
  assign key_activity = key_digit || key_clear || key_back || key_enter;

  assign in_collect  = (state_q == COLLECT);
  assign timer_run   = in_collect && enable;
  assign timer_clear = !in_collect || !enable || key_activity;

  pin_inactivity_timer #(
    .IDLE_TIMEOUT (IDLE_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .run    (timer_run),
    .expire (timer_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pw_q      <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      short_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      short_q   <= 1'b0;
      timeout_q <= 1'b0;
      if (!enable) begin
        // Session ended: never let a PIN linger.
        state_q <= IDLE;
        pw_q    <= '0;
        cnt_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            state_q <= COLLECT;
            pw_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
          end
          COLLECT: begin
            if (key_digit) begin
              if (cnt_q != 3'(DIGITS)) begin
                pw_q  <= {pw_q[PSW_W-DIGIT_W-1:0], DIGIT_W'(key_code)};
                cnt_q <= cnt_q + 3'd1;
              end
            end else if (key_back) begin
              if (cnt_q != 3'd0) begin
                pw_q  <= pw_q >> DIGIT_W;
                cnt_q <= cnt_q - 3'd1;
              end
            end else if (key_clear) begin
              pw_q  <= '0;
              cnt_q <= '0;
            end else if (key_enter) begin
              if (cnt_q == 3'(DIGITS)) begin
                state_q <= HOLD;
                valid_q <= 1'b1;
              end else begin
                short_q <= 1'b1;
              end
            end else if (timer_expire) begin
              pw_q      <= '0;
              cnt_q     <= '0;
              timeout_q <= 1'b1;
            end
          end
          HOLD: begin
            if (pin_ack) begin
              state_q <= COLLECT;
              pw_q    <= '0;
              cnt_q   <= '0;
              valid_q <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign password_input = pw_q;
  assign pin_valid      = valid_q;
  assign digit_count    = cnt_q;
  assign short_entry    = short_q;
  assign entry_timeout  = timeout_q;

endmodule
